// File: rtl/mem_stage_pkg.sv
// ----------------------------------------------------------------------------
// mem_stage_pkg
// Shared types and constants for the MIPS memory-access stage.
//   state_e            : controller states (IDLE / ACCESS / DONE / ERR)
//   BE_WORD            : byte-enable pattern for a full 32-bit word
//   MEM_BASE_DEFAULT   : byte address that maps to data-memory word 0
//   DM_AW_DEFAULT      : data-memory word-address width
//   WAIT_MAX_DEFAULT   : ACCESS cycles without dm_ack before a timeout error
// ----------------------------------------------------------------------------
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        ERR    = 2'd3
    } state_e;

    localparam logic [3:0]  BE_WORD          = 4'b1111;
    localparam logic [31:0] MEM_BASE_DEFAULT = 32'h0000_0400;
    localparam int          DM_AW_DEFAULT    = 10;
    localparam int          WAIT_MAX_DEFAULT = 15;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// ----------------------------------------------------------------------------
// mem_stage_ctrl_if
// Req/ack bus between the memory stage and the word-wide data memory.
//   dm_req   : request, held until dm_ack          (master -> slave)
//   dm_we    : write enable                        (master -> slave)
//   dm_addr  : word address, DM_AW bits            (master -> slave)
//   dm_be    : byte enables, bit i = lane i        (master -> slave)
//   dm_wdata : write data                          (master -> slave)
//   dm_rdata : read data, valid with dm_ack        (slave -> master)
//   dm_ack   : acknowledge                         (slave -> master)
// ----------------------------------------------------------------------------
interface mem_stage_ctrl_if
    import mem_stage_pkg::*;
#(
    parameter int DM_AW = DM_AW_DEFAULT
);
    logic             dm_req;
    logic             dm_we;
    logic [DM_AW-1:0] dm_addr;
    logic [3:0]       dm_be;
    logic [31:0]      dm_wdata;
    logic [31:0]      dm_rdata;
    logic             dm_ack;

    modport master (
        output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
        input  dm_rdata, dm_ack
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
        output dm_rdata, dm_ack
    );
endinterface

// File: rtl/mem_byte_lane.sv
// ----------------------------------------------------------------------------
// mem_byte_lane
// Combinational byte-lane steering shared by the store and load paths.
//   we, byte_op  : access type (store/load, byte/word)
//   lane         : byte offset within the word (address bits [1:0])
//   store_data   : register value to be stored
//   load_data    : raw word returned by the data memory
//   be, wdata    : byte enables and lane-replicated write data
//   load_result  : word load, or selected byte extended to 32 bits
// Build option: define MEM_SIGN_EXT_EN to sign-extend byte loads
// (default zero-extends). Word accesses are unaffected.
// ----------------------------------------------------------------------------
module mem_byte_lane
    import mem_stage_pkg::*;
(
    input  logic        we,
    input  logic        byte_op,
    input  logic [1:0]  lane,
    input  logic [31:0] store_data,
    input  logic [31:0] load_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_result
);
    logic [7:0] ld_byte;

    // NOTE: every output gets a value on every path through the block,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        // Only byte stores narrow the enables; loads always fetch the word.
        be      = (we && byte_op) ? (4'b0001 << lane) : BE_WORD;
        // Replicating the byte lets the memory pick it up on any lane.
        wdata   = byte_op ? {4{store_data[7:0]}} : store_data;
        ld_byte = load_data[{lane, 3'b000} +: 8];
        if (byte_op) begin
`ifdef MEM_SIGN_EXT_EN
            load_result = {{24{ld_byte[7]}}, ld_byte};
`else
            load_result = {24'd0, ld_byte};
`endif
        end else begin
            load_result = load_data;
        end
    end
endmodule

// File: rtl/mem_stage_ctrl.sv
// ----------------------------------------------------------------------------
// mem_stage_ctrl
// Memory-access stage of the multicycle MIPS datapath. Translates the ALU
// byte address into a data-memory word address, checks range/alignment,
// runs a req/ack transaction with timeout and returns load data.
//   Clk, Reset     : clock, synchronous active-high reset
//   MEM_req        : start strobe (ignored unless IDLE)
//   MEM_WrEn       : 1 = store, 0 = load
//   ByteOp         : 1 = lb/sb, 0 = lw/sw
//   ALU_MEM_Addr   : byte address
//   MEM_DataIn     : store data
//   MEM_DataOut    : registered load result, held until the next load
//   MEM_busy       : accept through DONE/ERR inclusive
//   MEM_done/err   : one-cycle completion / error pulses
//   dm             : data-memory bus (mem_stage_ctrl_if.master)
// Build option: MEM_SIGN_EXT_EN (handled in mem_byte_lane).
// ----------------------------------------------------------------------------
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter logic [31:0] MEM_BASE = MEM_BASE_DEFAULT,
    parameter int          DM_AW    = DM_AW_DEFAULT,
    parameter int          WAIT_MAX = WAIT_MAX_DEFAULT
)(
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 MEM_req,
    input  logic                 MEM_WrEn,
    input  logic                 ByteOp,
    input  logic [31:0]          ALU_MEM_Addr,
    input  logic [31:0]          MEM_DataIn,
    output logic [31:0]          MEM_DataOut,
    output logic                 MEM_busy,
    output logic                 MEM_done,
    output logic                 MEM_err,
    mem_stage_ctrl_if.master     dm
);
    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_ACCESS = ACCESS;
    localparam logic [1:0] S_DONE   = DONE;
    localparam logic [1:0] S_ERR    = ERR;
    localparam int         CW       = $clog2(WAIT_MAX + 1);

    logic [1:0]       state_q,    state_d;
    logic             we_q,       we_d;
    logic             byte_q,     byte_d;
    logic [1:0]       lane_q,     lane_d;
    logic [CW-1:0]    wait_cnt_q, wait_cnt_d;
    logic [31:0]      data_out_q, data_out_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;
    logic             err_q,      err_d;
    logic             dm_req_q,   dm_req_d;
    logic             dm_we_q,    dm_we_d;
    logic [DM_AW-1:0] dm_addr_q,  dm_addr_d;
    logic [3:0]       dm_be_q,    dm_be_d;
    logic [31:0]      dm_wdata_q, dm_wdata_d;

    logic [31:0] offset;
    logic        addr_err;
    logic        in_idle;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_load;

    assign offset   = ALU_MEM_Addr - MEM_BASE;
    assign addr_err = (ALU_MEM_Addr < MEM_BASE)
                    | (|offset[31:DM_AW+2])
                    | (!ByteOp && (|offset[1:0]));
    assign in_idle  = (state_q == S_IDLE);

    // One lane unit serves both directions: in IDLE it steers the incoming
    // store, afterwards it extracts from the latched lane for the load.
    mem_byte_lane u_lane (
        .we          (MEM_WrEn),
        .byte_op     (in_idle ? ByteOp : byte_q),
        .lane        (in_idle ? offset[1:0] : lane_q),
        .store_data  (MEM_DataIn),
        .load_data   (dm.dm_rdata),
        .be          (lane_be),
        .wdata       (lane_wdata),
        .load_result (lane_load)
    );

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        byte_d     = byte_q;
        lane_d     = lane_q;
        wait_cnt_d = wait_cnt_q;
        data_out_d = data_out_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        dm_req_d   = dm_req_q;
        dm_we_d    = dm_we_q;
        dm_addr_d  = dm_addr_q;
        dm_be_d    = dm_be_q;
        dm_wdata_d = dm_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (MEM_req) begin
                    we_d       = MEM_WrEn;
                    byte_d     = ByteOp;
                    lane_d     = offset[1:0];
                    wait_cnt_d = '0;
                    busy_d     = 1'b1;
                    if (addr_err) begin
                        // Bad address never reaches the memory bus.
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d    = S_ACCESS;
                        dm_req_d   = 1'b1;
                        dm_we_d    = MEM_WrEn;
                        dm_addr_d  = offset[DM_AW+1:2];
                        dm_be_d    = lane_be;
                        dm_wdata_d = lane_wdata;
                    end
                end
            end
            S_ACCESS: begin
                if (dm.dm_ack) begin
                    dm_req_d = 1'b0;
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    if (!we_q) data_out_d = lane_load;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                    if (wait_cnt_q == CW'(WAIT_MAX - 1)) begin
                        dm_req_d = 1'b0;
                        state_d  = S_ERR;
                        err_d    = 1'b1;
                    end
                end
            end
            default: begin
                // DONE / ERR: single-cycle pulse state, new requests dropped.
                state_d    = S_IDLE;
                busy_d     = 1'b0;
                wait_cnt_d = '0;
            end
        endcase
    end

    // NOTE: non-blocking assignments here so every flop samples the
    // pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            we_q       <= 1'b0;
            byte_q     <= 1'b0;
            lane_q     <= 2'd0;
            wait_cnt_q <= '0;
            data_out_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            dm_req_q   <= 1'b0;
            dm_we_q    <= 1'b0;
            dm_addr_q  <= '0;
            dm_be_q    <= 4'd0;
            dm_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            byte_q     <= byte_d;
            lane_q     <= lane_d;
            wait_cnt_q <= wait_cnt_d;
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            dm_req_q   <= dm_req_d;
            dm_we_q    <= dm_we_d;
            dm_addr_q  <= dm_addr_d;
            dm_be_q    <= dm_be_d;
            dm_wdata_q <= dm_wdata_d;
        end
    end

    assign MEM_DataOut = data_out_q;
    assign MEM_busy    = busy_q;
    assign MEM_done    = done_q;
    assign MEM_err     = err_q;
    assign dm.dm_req   = dm_req_q;
    assign dm.dm_we    = dm_we_q;
    assign dm.dm_addr  = dm_addr_q;
    assign dm.dm_be    = dm_be_q;
    assign dm.dm_wdata = dm_wdata_q;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mem_stage_ctrl
// Directed bench for mem_stage_ctrl: word/byte stores and loads, address
// errors, ack timeout, busy-time request rejection and mid-access reset.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
// ----------------------------------------------------------------------------
module tb_mem_stage_ctrl;
    logic        Clk = 1'b0;
    logic        Reset;
    logic        MEM_req;
    logic        MEM_WrEn;
    logic        ByteOp;
    logic [31:0] ALU_MEM_Addr;
    logic [31:0] MEM_DataIn;
    logic [31:0] MEM_DataOut;
    logic        MEM_busy;
    logic        MEM_done;
    logic        MEM_err;

    int n_cmp = 0;
    int n_err = 0;
    int req_rises = 0;
    int rises_before;
    logic req_prev = 1'b0;

    mem_stage_ctrl_if #(.DM_AW(10)) dm_if ();

    mem_stage_ctrl dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .MEM_req      (MEM_req),
        .MEM_WrEn     (MEM_WrEn),
        .ByteOp       (ByteOp),
        .ALU_MEM_Addr (ALU_MEM_Addr),
        .MEM_DataIn   (MEM_DataIn),
        .MEM_DataOut  (MEM_DataOut),
        .MEM_busy     (MEM_busy),
        .MEM_done     (MEM_done),
        .MEM_err      (MEM_err),
        .dm           (dm_if)
    );

    always #5 Clk = ~Clk;

    // Counts dm_req rising transitions to detect duplicate transactions.
    always @(posedge Clk) begin
        if (dm_if.dm_req && !req_prev) req_rises <= req_rises + 1;
        req_prev <= dm_if.dm_req;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic request(input logic wr, input logic bop, input logic [31:0] addr,
                           input logic [31:0] data);
        MEM_req      = 1'b1;
        MEM_WrEn     = wr;
        ByteOp       = bop;
        ALU_MEM_Addr = addr;
        MEM_DataIn   = data;
        tick();
        MEM_req      = 1'b0;
    endtask

    logic [31:0] lb_exp;

    initial begin
`ifdef MEM_SIGN_EXT_EN
        lb_exp = 32'hFFFF_FF80;
`else
        lb_exp = 32'h0000_0080;
`endif
        Reset = 1'b1; MEM_req = 1'b0; MEM_WrEn = 1'b0; ByteOp = 1'b0;
        ALU_MEM_Addr = '0; MEM_DataIn = '0;
        dm_if.dm_ack = 1'b0; dm_if.dm_rdata = '0;
        tick(); tick();
        Reset = 1'b0;

        // Reset state
        check("rst_dataout", MEM_DataOut, 32'h0);
        check("rst_busy",    {31'd0, MEM_busy}, 32'd0);
        check("rst_done",    {31'd0, MEM_done}, 32'd0);
        check("rst_err",     {31'd0, MEM_err},  32'd0);
        check("rst_dm_req",  {31'd0, dm_if.dm_req}, 32'd0);
        check("rst_dm_be",   {28'd0, dm_if.dm_be},  32'd0);
        check("rst_dm_addr", {22'd0, dm_if.dm_addr}, 32'd0);

        // 1. sw 0x404, ack two cycles after dm_req
        request(1'b1, 1'b0, 32'h404, 32'hDEADBEEF);
        check("sw_req",   {31'd0, dm_if.dm_req}, 32'd1);
        check("sw_addr",  {22'd0, dm_if.dm_addr}, 32'd1);
        check("sw_we",    {31'd0, dm_if.dm_we}, 32'd1);
        check("sw_be",    {28'd0, dm_if.dm_be}, 32'hF);
        check("sw_wdata", dm_if.dm_wdata, 32'hDEADBEEF);
        check("sw_busy",  {31'd0, MEM_busy}, 32'd1);
        tick();
        check("sw_req_hold", {31'd0, dm_if.dm_req}, 32'd1);
        check("sw_no_done",  {31'd0, MEM_done}, 32'd0);
        dm_if.dm_ack = 1'b1;
        tick();
        dm_if.dm_ack = 1'b0;
        check("sw_done",   {31'd0, MEM_done}, 32'd1);
        check("sw_err",    {31'd0, MEM_err}, 32'd0);
        check("sw_req_dn", {31'd0, dm_if.dm_req}, 32'd0);
        check("sw_busy_dn",{31'd0, MEM_busy}, 32'd1);
        tick();
        check("sw_done_1p", {31'd0, MEM_done}, 32'd0);
        check("sw_idle",    {31'd0, MEM_busy}, 32'd0);

        // 2. lw 0x408, ack in first ACCESS cycle
        request(1'b0, 1'b0, 32'h408, 32'h0);
        check("lw_addr", {22'd0, dm_if.dm_addr}, 32'd2);
        check("lw_we",   {31'd0, dm_if.dm_we}, 32'd0);
        check("lw_be",   {28'd0, dm_if.dm_be}, 32'hF);
        check("lw_cyc1_done", {31'd0, MEM_done}, 32'd0);
        dm_if.dm_ack = 1'b1; dm_if.dm_rdata = 32'h12345678;
        tick();
        dm_if.dm_ack = 1'b0;
        check("lw_cyc2_done", {31'd0, MEM_done}, 32'd1);
        check("lw_data", MEM_DataOut, 32'h12345678);
        tick();

        // 3. sb 0x405 then lb 0x407
        request(1'b1, 1'b1, 32'h405, 32'h000000AB);
        check("sb_be",    {28'd0, dm_if.dm_be}, 32'h2);
        check("sb_wdata", dm_if.dm_wdata, 32'hABABABAB);
        check("sb_addr",  {22'd0, dm_if.dm_addr}, 32'd1);
        dm_if.dm_ack = 1'b1; dm_if.dm_rdata = 32'h55555555;
        tick();
        dm_if.dm_ack = 1'b0;
        check("sb_done", {31'd0, MEM_done}, 32'd1);
        check("sb_keep_data", MEM_DataOut, 32'h12345678);
        tick();
        request(1'b0, 1'b1, 32'h407, 32'h0);
        check("lb_be",   {28'd0, dm_if.dm_be}, 32'hF);
        check("lb_addr", {22'd0, dm_if.dm_addr}, 32'd1);
        dm_if.dm_ack = 1'b1; dm_if.dm_rdata = 32'h80FF0011;
        tick();
        dm_if.dm_ack = 1'b0;
        check("lb_data", MEM_DataOut, lb_exp);
        tick();

        // dm_ack while IDLE must not disturb anything
        dm_if.dm_ack = 1'b1; dm_if.dm_rdata = 32'hFFFF0000;
        tick();
        dm_if.dm_ack = 1'b0;
        check("idle_ack_done", {31'd0, MEM_done}, 32'd0);
        check("idle_ack_data", MEM_DataOut, lb_exp);

        // 4. Address errors: misaligned, below base, beyond range
        rises_before = req_rises;
        request(1'b0, 1'b0, 32'h406, 32'h0);
        check("mis_err",  {31'd0, MEM_err}, 32'd1);
        check("mis_req",  {31'd0, dm_if.dm_req}, 32'd0);
        check("mis_busy", {31'd0, MEM_busy}, 32'd1);
        tick();
        check("mis_err_1p", {31'd0, MEM_err}, 32'd0);
        request(1'b0, 1'b0, 32'h3FC, 32'h0);
        check("low_err", {31'd0, MEM_err}, 32'd1);
        check("low_req", {31'd0, dm_if.dm_req}, 32'd0);
        tick();
        request(1'b0, 1'b0, 32'h1400, 32'h0);
        check("high_err", {31'd0, MEM_err}, 32'd1);
        tick();
        check("err_no_req",  req_rises, rises_before);
        check("err_keep_dat", MEM_DataOut, lb_exp);

        // 5. Timeout: lw 0x400 with dm_ack never asserted
        request(1'b0, 1'b0, 32'h400, 32'h0);
        for (int i = 1; i < 15; i++) begin
            check("to_wait_err", {31'd0, MEM_err}, 32'd0);
            check("to_wait_req", {31'd0, dm_if.dm_req}, 32'd1);
            tick();
        end
        check("to_last_err", {31'd0, MEM_err}, 32'd0);
        tick();
        check("to_err",  {31'd0, MEM_err}, 32'd1);
        check("to_req",  {31'd0, dm_if.dm_req}, 32'd0);
        check("to_done", {31'd0, MEM_done}, 32'd0);
        tick();
        check("to_idle", {31'd0, MEM_busy}, 32'd0);
        check("to_err_1p", {31'd0, MEM_err}, 32'd0);

        // 6a. MEM_req held through busy and DONE -> one transaction only
        rises_before = req_rises;
        request(1'b0, 1'b0, 32'h40C, 32'h0);
        MEM_req = 1'b1; ALU_MEM_Addr = 32'h410;
        tick();
        check("busy_addr", {22'd0, dm_if.dm_addr}, 32'd3);
        dm_if.dm_ack = 1'b1; dm_if.dm_rdata = 32'hCAFEF00D;
        tick();
        dm_if.dm_ack = 1'b0;
        check("busy_done", {31'd0, MEM_done}, 32'd1);
        check("busy_data", MEM_DataOut, 32'hCAFEF00D);
        tick();
        MEM_req = 1'b0;
        check("busy_idle", {31'd0, MEM_busy}, 32'd0);
        tick();
        check("busy_noreq", {31'd0, dm_if.dm_req}, 32'd0);
        check("busy_one_txn", req_rises, rises_before + 1);

        // 6b. Reset during ACCESS
        request(1'b0, 1'b0, 32'h400, 32'h0);
        check("mid_req", {31'd0, dm_if.dm_req}, 32'd1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("mid_rst_req",  {31'd0, dm_if.dm_req}, 32'd0);
        check("mid_rst_busy", {31'd0, MEM_busy}, 32'd0);
        check("mid_rst_data", MEM_DataOut, 32'h0);
        check("mid_rst_done", {31'd0, MEM_done | MEM_err}, 32'd0);
        tick();
        check("mid_after", {31'd0, MEM_done | MEM_err | dm_if.dm_req}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
